// File: rtl/dmem_pkg.sv
// Shared encodings for the load/store unit and the CPU decoder: access sizes,
// controller states, the latched request record and the request error rule.
package dmem_pkg;

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = 8;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

   // Only the byte offset and the low half of store data are needed after accept.
   typedef struct packed {
      logic        we;
      size_e       size;
      logic        uns;
      logic [1:0]  off;
      logic [15:0] wdata;
   } req_t;

   function automatic logic addr_err(input size_e size, input logic [31:0] addr,
                                     input int addr_w);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr[0];
         SZ_WORD: bad = |addr[1:0];
         default: bad = 1'b1;
      endcase
      return bad | ((addr >> (addr_w + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts/extends a sub-word load from a memory word and
// merges sub-word store data into that word for read-modify-write.
module lsu_lane
   import dmem_pkg::*;
(
   input  size_e       size,
   input  logic        uns,
   input  logic [1:0]  off,
   input  logic [31:0] rword,
   input  logic [15:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] mword
);

   logic [NUM_LANES-1:0]        be;
   logic [NUM_LANES*LANE_W-1:0] wrep;
   logic [31:0]                 sh;

   assign sh = rword >> {off, 3'b000};

   always_comb begin
      be    = '0;
      wrep  = {2{wdata}};
      ldata = sh;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << off;
            wrep  = {4{wdata[7:0]}};
            ldata = {{24{~uns & sh[7]}}, sh[7:0]};
         end
         SZ_HALF: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            ldata = {{16{~uns & sh[15]}}, sh[15:0]};
         end
         default: ;
      endcase
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign mword[i*LANE_W +: LANE_W] = be[i] ? wrep[i*LANE_W +: LANE_W]
                                               : rword[i*LANE_W +: LANE_W];
   end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store controller for a single-port word memory: one request at a time,
// sub-word stores done as read-modify-write, all outputs registered.
module lsu_dmem
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_w,
   output logic        mem_rw,
   input  logic [31:0] mem_data_r
);

   state_e      state;
   req_t        r;
   logic [31:0] ldata;
   logic [31:0] mword;

   assign req_ready = rst_n && (state == ST_IDLE);

   lsu_lane u_lane (
      .size  (r.size),
      .uns   (r.uns),
      .off   (r.off),
      .rword (mem_data_r),
      .wdata (r.wdata),
      .ldata (ldata),
      .mword (mword)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         r          <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_data_w <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               rsp_valid <= 1'b0;
               mem_rw    <= 1'b0;
               if (req_valid) begin
                  r <= '{we: req_we, size: size_e'(req_size), uns: req_unsigned,
                         off: req_addr[1:0], wdata: req_wdata[15:0]};
                  mem_addr <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                  if (addr_err(size_e'(req_size), req_addr, ADDR_W)) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (req_we && size_e'(req_size) == SZ_WORD) begin
                     // Full-word store skips the read and writes directly.
                     state      <= ST_WRITE;
                     mem_rw     <= 1'b1;
                     mem_data_w <= req_wdata;
                  end else begin
                     state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               mem_data_w <= mword;
               if (r.we) begin
                  state  <= ST_WRITE;
                  mem_rw <= 1'b1;
               end else begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= ldata;
               end
            end
            ST_WRITE: begin
               mem_rw    <= 1'b0;
               state     <= ST_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dmem.sv
// Randomized scoreboard bench for lsu_dmem with a byte-level reference memory.
module tb_lsu_dmem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, mem_rw;
   logic [31:0] rsp_rdata, mem_addr, mem_data_w, mem_data_r;

   always #5 clk = ~clk;

   lsu_dmem #(.ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
      .mem_data_w(mem_data_w), .mem_rw(mem_rw), .mem_data_r(mem_data_r)
   );

   function automatic logic [31:0] pat(input int i);
      return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   // Bench-owned data memory: combinational read, negedge write.
   logic [31:0] mem [1024];
   logic        mem_init = 1'b0;
   assign mem_data_r = mem[mem_addr[9:0]];
   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
         mem_init <= 1'b1;
      end else if (mem_rw) begin
         mem[mem_addr[9:0]] <= mem_data_w;
      end
   end

   logic [31:0] ref_mem [1024];
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nwr;
      logic [9:0]  idx;
      logic [31:0] wword;
      int          acc;
   } exp_t;
   exp_t q[$];

   int n_chk = 0, n_fail = 0, rw_cnt = 0;
   logic [31:0] last_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference model works on bytes: little-endian lanes, size in bytes.
   function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input int acc);
      exp_t e;
      int nb, off;
      logic [31:0] w, v;
      e.acc = acc; e.idx = addr[11:2]; e.rdata = '0; e.nwr = 0; e.wword = '0;
      off = int'(addr[1:0]);
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e.err = (size == 2'd3) || (off % nb != 0) || (addr >= 32'h1000);
      e.lat = 1;
      if (!e.err && !we) begin
         w = ref_mem[e.idx];
         v = '0;
         for (int k = 0; k < nb; k++) v[8*k +: 8] = w[8*(off+k) +: 8];
         if (!uns && v[8*nb-1])
            for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
         e.rdata = v;
         e.lat   = 2;
      end else if (!e.err) begin
         w = ref_mem[e.idx];
         for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wdata[8*k +: 8];
         ref_mem[e.idx] = w;
         e.wword = w;
         e.nwr   = 1;
         e.lat   = (nb == 4) ? 2 : 3;
      end
      return e;
   endfunction

   // Monitor: checks every write pulse and every response against the queue head.
   always @(negedge clk) begin
      if (mem_rw) begin
         rw_cnt++;
         if (q.size() == 0) flag_fail("rw_unexpected");
         else begin
            check("wr_addr", mem_addr, {22'd0, q[0].idx});
            check("wr_data", mem_data_w, q[0].wword);
         end
      end
      if (rst_n && rsp_valid) begin
         if (q.size() == 0) flag_fail("rsp_unexpected");
         else begin
            exp_t e;
            e = q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            check("latency", cyc + 1 - e.acc, e.lat);
            check("rw_pulses", rw_cnt, e.nwr);
            last_rdata = rsp_rdata;
         end
         rw_cnt = 0;
      end
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int t = 0;
      @(negedge clk);
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      if (!req_ready) begin flag_fail("ready_timeout"); return; end
      q.push_back(model(we, size, uns, addr, wdata, cyc + 1));
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
      if (q.size() != 0) begin flag_fail("drain_timeout"); q.delete(); end
   endtask

   initial begin
      int nmis;
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
      rst_n = 1'b0;
      // Request held during reset must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_data_w", mem_data_w, 32'd0);
      req_valid = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_ready", {31'd0, req_ready}, 32'd1);

      // Word store, then signed/unsigned byte loads of the top byte.
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF); drain();
      check("word_store_mem", mem[4], 32'hDEADBEEF);
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01); drain();
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0); drain();
      check("lb_signed", last_rdata, 32'hFFFFFF80);
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0); drain();
      check("lb_unsigned", last_rdata, 32'h00000080);

      // Byte store read-modify-write.
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344); drain();
      issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA); drain();
      check("byte_store_mem", mem[4], 32'h1122AA44);

      // Error cases: misaligned half, out-of-range word store, reserved size.
      issue(1'b0, 2'd1, 1'b0, 32'h03, 32'h0); drain();
      issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678); drain();
      check("oob_mem0", mem[0], pat(0));
      issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0); drain();

      // Reset landing on the WRITE cycle of a half store.
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344); drain();
      issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF);
      begin
         int t = 0;
         while (!mem_rw && t < 10) begin @(negedge clk); t++; end
         if (!mem_rw) flag_fail("write_wait");
      end
      rst_n = 1'b0;
      @(posedge clk);
      q.delete();
      rw_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);
      repeat (5) @(negedge clk);
      check("rst_write_mem", mem[8], 32'hBEEF3344);

      // Randomized traffic, mostly within a small window to force reuse.
      for (int n = 0; n < 200; n++) begin
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
         issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      end
      drain();

      nmis = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nmis++;
      check("mem_final", nmis, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_dmem.md
LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 Parameter ADDR_W, default 10, word-index width of the attached data memory (1024 words).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  controller can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  in  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-013 rsp_err  out  1  misaligned, reserved-size or out-of-range request; qualified by rsp_valid.
REQ-014 mem_addr  out  32  word index to memory: {zeros, addr[ADDR_W+1:2]}.
REQ-015 mem_data_w  out  32  word to write.
REQ-016 mem_rw  out  1  memory write enable; memory writes on negedge clk while high.
REQ-017 mem_data_r  in  32  combinational memory read data for mem_addr.

Function
REQ-018 FSM states are IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: on req_valid=1, latch all req_* fields; on error go to RESP with err=1; on a word store go to WRITE; otherwise go to READ.
REQ-020 Error conditions are: half access with addr[0]=1; word access with addr[1:0]!=0; req_size=11; any of addr[31:ADDR_W+2] nonzero.
REQ-021 An errored request SHALL issue no mem_rw pulse.
REQ-022 READ lasts one cycle with mem_addr driven and mem_data_r captured at its closing posedge.
REQ-023 From READ, a load goes to RESP and a sub-word store goes to WRITE.
REQ-024 Load extraction: select byte addr[1:0] or half addr[1] (little-endian), then extend per req_unsigned to 32 bits.
REQ-025 Sub-word store: merge req_wdata[7:0]/[15:0] into the captured word at the addressed lane, leaving other lanes unchanged (read-modify-write).
REQ-026 WRITE lasts exactly one cycle with mem_rw=1 (registered output), mem_addr stable and mem_data_w = merged word; mem_rw SHALL be 0 in every other state.
REQ-027 RESP drives rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_err valid, then returns to IDLE; there is no back-pressure on the response.
REQ-028 Latency from accept edge to rsp_valid: load 2 cycles; word store 2; sub-word store 3; error 1.
REQ-029 mem_addr SHALL hold the latched word index from READ through RESP; in IDLE it is don't-care but stable at the last value.

Reset
REQ-030 While rst_n=0 at a posedge: state becomes IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rw=0, mem_addr=0, mem_data_w=0.
REQ-031 Reset asserted during WRITE takes effect at the next posedge; the negedge write of that cycle completes, and no rsp_valid follows.
REQ-032 A request presented during reset is not accepted.

Structure
REQ-033 The size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encoding belong in shared package dmem_pkg, reused by the CPU decoder.
REQ-034 Lane extract/merge logic is one combinational sub-module, lsu_lane; the FSM stays in lsu_dmem.

Verification
REQ-035 Word store: addr 0x10, data 0xDEADBEEF -> single mem_rw pulse, mem_addr 4, memory[4]=0xDEADBEEF, rsp_valid 2 cycles after accept.
REQ-036 Signed byte load: addr 0x13 with memory[4]=0x80FF7F01 -> rsp_rdata 0xFFFFFF80; the same load with unsigned=1 -> 0x00000080.
REQ-037 Byte store: addr 0x11, data 0xAA over memory[4]=0x11223344 -> memory[4]=0x1122AA44, with mem_rw high exactly one cycle.
REQ-038 Misaligned half: addr 0x03 -> rsp_err=1, rsp_rdata=0, no mem_rw, rsp_valid 1 cycle after accept.
REQ-039 Out-of-range: addr 0x1000 (ADDR_W=10) -> rsp_err=1 with memory unchanged.
REQ-040 Reset during WRITE of a half store -> memory updated, no rsp_valid, req_ready=1 in the cycle after the reset edge with rst_n released.
